mat_mac_accum: RTL



---
 rtl/mat_mac_accum.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/mat_mac_accum.sv
// Two-stage signed multiply-accumulate with result handshake and run FSM.
// Optional: MAT_MAC_SATURATE_EN clamps accumulator adds instead of wrapping.
`timescale 1ns/1ps
module mat_mac_accum #(
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 20,
  parameter int VEC_LEN = 8,
  parameter int N_RES   = 64,
  parameter int RES_AW  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data,
  output logic [RES_AW-1:0] res_addr,
  output logic              busy,
  output logic              done
);

  localparam int PW = 2 * DATA_W;
  localparam int EW = $clog2(VEC_LEN);

  localparam logic [EW-1:0] ELEM_LAST =
    EW'(VEC_LEN - 1);
  localparam logic [RES_AW-1:0] RES_LAST =
    RES_AW'(N_RES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t state;

  logic [EW-1:0]     elem;
  logic [RES_AW-1:0] vec;
  logic              all_in;

  logic              s1_valid;
  logic signed [PW-1:0] s1_p;
  logic              s1_first;
  logic              s1_last;

  logic signed [ACC_W-1:0] acc;
  logic              s2_done;

  logic stall;
  logic accept;
  logic res_take;
  logic last_elem;

  logic signed [PW-1:0]    ax;
  logic signed [PW-1:0]    bx;
  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] ext;
  logic signed [ACC_W:0]   sum;
  logic signed [ACC_W-1:0] add_res;
  logic signed [ACC_W-1:0] acc_next;

  assign stall     = res_valid & ~res_ready;
  assign in_ready  = (state == RUN) & ~all_in
                   & ~stall;
  assign accept    = in_valid & in_ready;
  assign res_take  = res_valid & res_ready;
  assign last_elem = (elem == ELEM_LAST);

  assign busy = (state == RUN);
  assign done = (state == FIN);

  assign ax   = PW'($signed(a));
  assign bx   = PW'($signed(b));
  assign prod = ax * bx;

  assign ext = ACC_W'(s1_p);
  assign sum = (ACC_W+1)'(acc)
             + (ACC_W+1)'(ext);

`ifdef MAT_MAC_SATURATE_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX =
    {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN =
    {1'b1, {(ACC_W-1){1'b0}}};

  // Top two sum bits disagree only on overflow.
  always_comb begin
    add_res = sum[ACC_W-1:0];
    if (sum[ACC_W] != sum[ACC_W-1])
      add_res = sum[ACC_W] ? ACC_MIN : ACC_MAX;
  end
`else
  assign add_res = sum[ACC_W-1:0];
`endif

  assign acc_next = s1_first ? ext : add_res;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      elem   <= '0;
      vec    <= '0;
      all_in <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state  <= RUN;
            elem   <= '0;
            vec    <= '0;
            all_in <= 1'b0;
          end
        end
        RUN: begin
          if (accept) begin
            if (last_elem) begin
              elem <= '0;
              if (vec == RES_LAST)
                all_in <= 1'b1;
              else
                vec <= vec + 1'b1;
            end else begin
              elem <= elem + 1'b1;
            end
          end
          if (res_take && res_addr == RES_LAST)
            state <= FIN;
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_p     <= '0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      acc      <= '0;
      s2_done  <= 1'b0;
    end else if (!stall) begin
      s1_valid <= accept;
      if (accept) begin
        s1_p     <= prod;
        s1_first <= (elem == '0);
        s1_last  <= last_elem;
      end
      s2_done <= s1_valid & s1_last;
      if (s1_valid)
        acc <= acc_next;
    end
  end

  // A held result stalls the pipe, so a load never overwrites one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_addr  <= '0;
    end else begin
      if (!stall && s2_done) begin
        res_valid <= 1'b1;
        res_data  <= acc;
      end else if (res_take) begin
        res_valid <= 1'b0;
      end
      if (res_take)
        res_addr <= (res_addr == RES_LAST)
                  ? '0 : res_addr + 1'b1;
    end
  end

endmodule
